// File: rtl/enc_4_2_seq.sv
// Sequential priority encoder: captures a multi-hot request vector and serves
// the index of each set bit, highest first, one per out_valid/out_ready handshake.
module enc_4_2_seq #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] Din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Dout,
    output logic         last,
    output logic [W:0]   pend_cnt,
    output logic         zero_in
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [W:0] CNT_ONE = {{W{1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pending;
    logic [W:0]     r_pend_cnt;
    logic           r_zero_in;
    logic           w_load;
    logic           w_xfer;
    logic           w_din_nz;
    logic [W-1:0]   w_hi_idx;

    function automatic logic [W-1:0] f_hi_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    function automatic logic [W:0] f_popcount(input logic [N-1:0] v);
        logic [W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    assign w_din_nz = |Din;
    assign w_hi_idx = f_hi_idx(r_pending);
    assign w_load   = en & in_valid & (r_state == IDLE);
    assign w_xfer   = en & out_ready & (r_state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load && w_din_nz) w_state_nxt = BUSY;
            BUSY:    if (w_xfer && (r_pend_cnt == CNT_ONE)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only; en is the sole live gate.
    always_comb begin
        in_ready  = en & (r_state == IDLE);
        out_valid = en & (r_state == BUSY);
        Dout      = w_hi_idx;
        last      = (r_pend_cnt == CNT_ONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_pend_cnt <= '0;
            r_zero_in  <= 1'b0;
        end else begin
            r_zero_in <= w_load & ~w_din_nz;
            if (w_load && w_din_nz) begin
                r_pending  <= Din;
                r_pend_cnt <= f_popcount(Din);
            end else if (w_xfer) begin
                r_pending[w_hi_idx] <= 1'b0;
                r_pend_cnt          <= r_pend_cnt - CNT_ONE;
            end
        end
    end

    assign pend_cnt = r_pend_cnt;
    assign zero_in  = r_zero_in;

endmodule
